// File: rtl/alu_cmd_responder.sv
// ============================================================================
// Module   : alu_cmd_responder
// Purpose  : Valid/ready ALU responder with an optional iterative divider
//            (enabled by defining ALU_RSP_DIV_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_responder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [3:0]           req_op,
    input  logic [WIDTH-1:0]     req_a,
    input  logic [WIDTH-1:0]     req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [2*WIDTH-1:0]   rsp_result,
    output logic                 rsp_overflow,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int                c_SHW = $clog2(WIDTH);
    localparam logic [c_SHW:0]    c_WSZ = (c_SHW+1)'(WIDTH);

    localparam logic [3:0] c_OP_ADD  = 4'd0;
    localparam logic [3:0] c_OP_SUB  = 4'd1;
    localparam logic [3:0] c_OP_MUL  = 4'd2;
    localparam logic [3:0] c_OP_DIV  = 4'd3;
    localparam logic [3:0] c_OP_SLL  = 4'd4;
    localparam logic [3:0] c_OP_SRL  = 4'd5;
    localparam logic [3:0] c_OP_ROL  = 4'd6;
    localparam logic [3:0] c_OP_ROR  = 4'd7;
    localparam logic [3:0] c_OP_AND  = 4'd8;
    localparam logic [3:0] c_OP_OR   = 4'd9;
    localparam logic [3:0] c_OP_XOR  = 4'd10;
    localparam logic [3:0] c_OP_NOR  = 4'd11;
    localparam logic [3:0] c_OP_NAND = 4'd12;
    localparam logic [3:0] c_OP_XNOR = 4'd13;
    localparam logic [3:0] c_OP_GT   = 4'd14;
    localparam logic [3:0] c_OP_EQ   = 4'd15;

`ifdef ALU_RSP_DIV_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DIV = 2'd1, S_DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

    state_t                 state_q, state_d;
    logic [2*WIDTH-1:0]     result_q, result_d;
    logic                   ovf_q, ovf_d;
    logic                   err_q, err_d;

    logic [WIDTH-1:0]       w_zx;
    logic [c_SHW-1:0]       w_sh;
    logic [c_SHW:0]         w_inv_sh;
    logic [WIDTH:0]         w_sum;
    logic [2*WIDTH-1:0]     w_prod;
    logic [2*WIDTH-1:0]     w_alu_res;
    logic                   w_alu_ovf;
    logic                   w_alu_err;

`ifdef ALU_RSP_DIV_EN
    localparam logic [c_SHW-1:0] c_LAST = c_SHW'(WIDTH - 1);

    logic [WIDTH-1:0]       rem_q, rem_d;
    logic [WIDTH-1:0]       quo_q, quo_d;
    logic [WIDTH-1:0]       dvs_q, dvs_d;
    logic [c_SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH:0]         w_shift;
    logic                   w_div_ge;
    logic [WIDTH-1:0]       w_div_sub;
    logic [WIDTH-1:0]       w_rem_nx;
    logic [WIDTH-1:0]       w_quo_nx;

    // Restoring step: shift the next dividend bit into the partial remainder
    // and subtract the divisor only when it fits.
    always_comb begin
        w_shift   = {rem_q, quo_q[WIDTH-1]};
        w_div_ge  = (w_shift >= {1'b0, dvs_q});
        w_div_sub = w_shift[WIDTH-1:0] - dvs_q;
        w_rem_nx  = w_div_ge ? w_div_sub : w_shift[WIDTH-1:0];
        w_quo_nx  = {quo_q[WIDTH-2:0], w_div_ge};
    end
`endif

    always_comb begin
        w_zx      = '0;
        w_sh      = req_b[c_SHW-1:0];
        w_inv_sh  = c_WSZ - {1'b0, w_sh};
        w_sum     = {1'b0, req_a} + {1'b0, req_b};
        w_prod    = {w_zx, req_a} * {w_zx, req_b};
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        w_alu_err = 1'b0;
        case (req_op)
            c_OP_ADD: begin
                w_alu_res = {{(WIDTH-1){1'b0}}, w_sum};
                w_alu_ovf = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res = {w_zx, req_a - req_b};
                w_alu_ovf = (req_a < req_b);
            end
            c_OP_MUL:  w_alu_res = w_prod;
            c_OP_DIV:  w_alu_err = 1'b1;
            c_OP_SLL:  w_alu_res = {w_zx, req_a << w_sh};
            c_OP_SRL:  w_alu_res = {w_zx, req_a >> w_sh};
            c_OP_ROL:  w_alu_res = {w_zx, (req_a << w_sh) | (req_a >> w_inv_sh)};
            c_OP_ROR:  w_alu_res = {w_zx, (req_a >> w_sh) | (req_a << w_inv_sh)};
            c_OP_AND:  w_alu_res = {w_zx, req_a & req_b};
            c_OP_OR:   w_alu_res = {w_zx, req_a | req_b};
            c_OP_XOR:  w_alu_res = {w_zx, req_a ^ req_b};
            c_OP_NOR:  w_alu_res = {w_zx, ~(req_a | req_b)};
            c_OP_NAND: w_alu_res = {w_zx, ~(req_a & req_b)};
            c_OP_XNOR: w_alu_res = {w_zx, ~(req_a ^ req_b)};
            c_OP_GT:   w_alu_res = {{(2*WIDTH-1){1'b0}}, (req_a > req_b)};
            c_OP_EQ:   w_alu_res = {{(2*WIDTH-1){1'b0}}, (req_a == req_b)};
            default:   w_alu_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
`ifdef ALU_RSP_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d  = S_DONE;
                    result_d = w_alu_res;
                    ovf_d    = w_alu_ovf;
                    err_d    = w_alu_err;
`ifdef ALU_RSP_DIV_EN
                    // A non-zero divisor diverts into the iterative divider.
                    if (req_op == c_OP_DIV && req_b != '0) begin
                        state_d  = S_DIV;
                        result_d = '0;
                        ovf_d    = 1'b0;
                        err_d    = 1'b0;
                        rem_d    = '0;
                        quo_d    = req_a;
                        dvs_d    = req_b;
                        cnt_d    = '0;
                    end
`endif
                end
            end
`ifdef ALU_RSP_DIV_EN
            S_DIV: begin
                rem_d = w_rem_nx;
                quo_d = w_quo_nx;
                cnt_d = cnt_q + c_SHW'(1);
                if (cnt_q == c_LAST) begin
                    state_d  = S_DONE;
                    result_d = {w_rem_nx, w_quo_nx};
                end
            end
`endif
            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef ALU_RSP_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
`ifdef ALU_RSP_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = (state_q == S_DONE);
    assign busy         = (state_q != S_IDLE);
    assign rsp_result   = result_q;
    assign rsp_overflow = ovf_q;
    assign rsp_err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_responder.sv
// ============================================================================
// Module   : tb_alu_cmd_responder
// Purpose  : Directed self-checking bench for alu_cmd_responder (WIDTH=8).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_responder;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [3:0]         req_op;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_result;
    logic               rsp_overflow;
    logic               rsp_err;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_cmd_responder #(.WIDTH(WIDTH)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_overflow (rsp_overflow),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for the response, check it, then retire it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [15:0] exp_res,
                          input logic exp_ovf, input logic exp_err, input int exp_lat);
        int  n;
        int  lat;
        bit  side_ok;
        n = 0;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_op    = op ^ 4'hF;
        req_a     = ~a;
        req_b     = ~b;
        lat       = 0;
        side_ok   = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (!busy || req_ready) side_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy"}, {31'd0, side_ok}, 32'd1);
        check({tag, "_res"}, {16'd0, rsp_result}, {16'd0, exp_res});
        check({tag, "_ovf"}, {31'd0, rsp_overflow}, {31'd0, exp_ovf});
        check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 4'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_result", {16'd0, rsp_result}, 32'd0);
        check("rst_ovf", {31'd0, rsp_overflow}, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        run_op("add", 4'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 0);
`ifdef ALU_RSP_DIV_EN
        run_op("div", 4'd3, 8'd100, 8'd7, 16'h020E, 1'b0, 1'b0, WIDTH);
`else
        run_op("div", 4'd3, 8'd100, 8'd7, 16'h0000, 1'b0, 1'b1, 0);
`endif
        run_op("div0", 4'd3, 8'd55, 8'd0, 16'h0000, 1'b0, 1'b1, 0);

        // Backpressure on a rotate result.
        req_op = 4'd6; req_a = 8'h81; req_b = 8'd1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", {31'd0, rsp_valid}, 32'd1);
            check("bp_result", {16'd0, rsp_result}, 32'h0003);
            check("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_release_ready", {31'd0, req_ready}, 32'd1);
        check("bp_release_valid", {31'd0, rsp_valid}, 32'd0);

        run_op("sub", 4'd1, 8'd5, 8'd9, 16'h00FC, 1'b1, 1'b0, 0);
        run_op("mul", 4'd2, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 0);
        run_op("eq", 4'd15, 8'h55, 8'h55, 16'h0001, 1'b0, 1'b0, 0);
        run_op("nand", 4'd12, 8'hF0, 8'hCC, 16'h003F, 1'b0, 1'b0, 0);
        run_op("add_carry", 4'd0, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0, 0);
        run_op("sub_nob", 4'd1, 8'd9, 8'd5, 16'h0004, 1'b0, 1'b0, 0);
        run_op("sll", 4'd4, 8'h81, 8'd3, 16'h0008, 1'b0, 1'b0, 0);
        run_op("sll_amt", 4'd4, 8'h01, 8'h09, 16'h0002, 1'b0, 1'b0, 0);
        run_op("srl", 4'd5, 8'h81, 8'd3, 16'h0010, 1'b0, 1'b0, 0);
        run_op("ror", 4'd7, 8'h81, 8'd1, 16'h00C0, 1'b0, 1'b0, 0);
        run_op("rol0", 4'd6, 8'hA5, 8'd0, 16'h00A5, 1'b0, 1'b0, 0);
        run_op("and", 4'd8, 8'hF0, 8'hCC, 16'h00C0, 1'b0, 1'b0, 0);
        run_op("or", 4'd9, 8'hF0, 8'hCC, 16'h00FC, 1'b0, 1'b0, 0);
        run_op("xor", 4'd10, 8'hF0, 8'hCC, 16'h003C, 1'b0, 1'b0, 0);
        run_op("nor", 4'd11, 8'hF0, 8'hCC, 16'h0003, 1'b0, 1'b0, 0);
        run_op("xnor", 4'd13, 8'hF0, 8'hCC, 16'h00C3, 1'b0, 1'b0, 0);
        run_op("gt_t", 4'd14, 8'd3, 8'd2, 16'h0001, 1'b0, 1'b0, 0);
        run_op("gt_f", 4'd14, 8'd2, 8'd3, 16'h0000, 1'b0, 1'b0, 0);
        run_op("eq_f", 4'd15, 8'h55, 8'h54, 16'h0000, 1'b0, 1'b0, 0);

        // Reset three cycles into a divide discards it.
        req_op = 4'd3; req_a = 8'd100; req_b = 8'd7; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_result", {16'd0, rsp_result}, 32'd0);
        check("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        seen = 1'b0;
        repeat (12) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
        run_op("post_rst_add", 4'd0, 8'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 0);

        // Reset beats a simultaneous request.
        reset = 1'b1; req_op = 4'd0; req_a = 8'd1; req_b = 8'd2; req_valid = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        check("rst_win_busy", {31'd0, busy}, 32'd0);
        check("rst_win_valid", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
